// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: reduces N_IN operands to one sum over L registered
// levels, followed by an output stage that either passes each tree result through
// or accumulates results across beats until an in_last beat closes the group.
module adder_tree_pipe #(
   parameter int N_IN  = 8,
   parameter int IN_W  = 32,
   parameter int ACC_W = 48
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic                   acc_mode,
   input  logic                   acc_clr,
   input  logic [N_IN*IN_W-1:0]   in_flat,
   output logic signed [ACC_W-1:0] sum_out,
   output logic                   out_valid,
   output logic                   acc_busy
);

   localparam int L     = $clog2(N_IN);
   localparam int SUM_W = IN_W + L;

   // Level 0 is the sign-extended input (combinational); level l (l>=1) holds the
   // registered pair sums of level l-1. Every element is carried at SUM_W, which is
   // wide enough for the full tree, so no level can overflow.
   for (genvar l = 0; l <= L; l++) begin : g_lvl
      localparam int CNT = (N_IN + (1 << l) - 1) >> l;

      logic signed [SUM_W-1:0] sum_q [CNT];
      logic                    vld_q;
      logic                    last_q;
      logic                    mode_q;

      if (l == 0) begin : g_in
         for (genvar k = 0; k < CNT; k++) begin : g_ext
            assign sum_q[k] = SUM_W'($signed(in_flat[k*IN_W +: IN_W]));
         end
         assign vld_q  = in_valid;
         assign last_q = in_last;
         assign mode_q = acc_mode;
      end else begin : g_reg
         localparam int PCNT = (N_IN + (1 << (l - 1)) - 1) >> (l - 1);

         logic signed [SUM_W-1:0] sum_d [CNT];

         // An unpaired last element is forwarded unchanged (added to zero).
         for (genvar k = 0; k < CNT; k++) begin : g_add
            if (2*k + 1 < PCNT) begin : g_pair
               assign sum_d[k] = g_lvl[l-1].sum_q[2*k] + g_lvl[l-1].sum_q[2*k+1];
            end else begin : g_odd
               assign sum_d[k] = g_lvl[l-1].sum_q[2*k];
            end
         end

         // Tree level register: pair sums plus the sideband travelling with them.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < CNT; k++) sum_q[k] <= '0;
               vld_q  <= 1'b0;
               last_q <= 1'b0;
               mode_q <= 1'b0;
            end else if (en) begin
               for (int k = 0; k < CNT; k++) sum_q[k] <= sum_d[k];
               vld_q  <= g_lvl[l-1].vld_q;
               last_q <= g_lvl[l-1].last_q;
               mode_q <= g_lvl[l-1].mode_q;
            end
         end
      end
   end

   logic signed [ACC_W-1:0] tree_ext;
   logic                    t_vld;
   logic                    t_last;
   logic                    t_mode;

   assign tree_ext = ACC_W'(g_lvl[L].sum_q[0]);
   assign t_vld    = g_lvl[L].vld_q;
   assign t_last   = g_lvl[L].last_q;
   assign t_mode   = g_lvl[L].mode_q;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] res_q, res_d;
   logic                    ovld_q, ovld_d;
   logic                    busy_q;

   // Output-stage next state: pass-through, accumulate, or close a group.
   // acc_clr wins over any accumulating beat but lets a pass-through beat out.
   always_comb begin
      acc_d  = acc_q;
      res_d  = res_q;
      ovld_d = 1'b0;
      if (t_vld) begin
         if (!t_mode) begin
            res_d  = tree_ext;
            ovld_d = 1'b1;
         end else if (!acc_clr) begin
            if (t_last) begin
               res_d  = acc_q + tree_ext;
               ovld_d = 1'b1;
               acc_d  = '0;
            end else begin
               acc_d  = acc_q + tree_ext;
            end
         end
      end
      if (acc_clr) acc_d = '0;
   end

   // Output-stage registers; everything holds while en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         res_q  <= '0;
         ovld_q <= 1'b0;
         busy_q <= 1'b0;
      end else if (en) begin
         acc_q  <= acc_d;
         res_q  <= res_d;
         ovld_q <= ovld_d;
         busy_q <= (acc_d != '0);
      end
   end

   assign sum_out   = res_q;
   assign out_valid = ovld_q;
   assign acc_busy  = busy_q;

endmodule
